rv32i_instr_encoder: RTL and testbench
======================================

Name: rv32i_instr_encoder

Overview:
Streaming RV32I instruction encoder. It is the inverse of the core's main/ALU decode path: it takes decoded fields (format, opcode, funct3, funct7b5, register indices, immediate) and packs them into a 32-bit instruction word. Words are queued in a 2-entry output FIFO, each tagged with a sequential instruction-memory word address. It sits between a test/boot program source and the instruction-memory write port.

Parameters:
ADDR_W, 8, width of the output word-address counter; wraps modulo 2^ADDR_W.
ERRCNT_W, 8, width of the saturating illegal-request counter.

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request
in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 illegal
in_op  in  7  opcode, copied to word[6:0]
in_funct3  in  3  funct3
in_funct7b5  in  1  funct7 bit 5 (R-type, I-type shifts)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  signed byte-offset / immediate value
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
out_instr  out  32  encoded word at head
out_addr  out  ADDR_W  word address of head
out_illegal  out  1  head came from an illegal request
err_count  out  ERRCNT_W  number of illegal requests accepted, saturating

Behaviour:
- Reset (async assert, sync-style release): FIFO count=0, out_valid=0, out_instr=0, out_addr=0, out_illegal=0, err_count=0, address counter=0. Reset mid-stream discards FIFO contents.
- Accept: in_valid && in_ready. in_ready = (count < 2), independent of out_ready. No push when full, even if a pop happens in the same cycle.
- Pop: out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- Latency: a word accepted at edge N is visible at the FIFO head after edge N when the FIFO was empty. Order is strictly FIFO.
- Address: each accepted request is stamped with the counter value, and the counter then increments, wrapping 2^ADDR_W-1 -> 0. Illegal requests also consume an address.
- Encoding (word[6:0]=in_op for all formats):
  R: {0,f7b5,00000, rs2, rs1, f3, rd, op}
  I: {imm[11:0], rs1, f3, rd, op}. If op=0010011 and f3 is 001 or 101 (shift), imm[11:5] is replaced by {0,f7b5,00000} and imm[4:0] holds shamt.
  S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  U: {imm[31:12], rd, op}
  J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Illegal request if any of the following holds:
  in_fmt > 5
  I/S: imm outside [-2048, 2047]
  I-shift: imm[31:5] != 0
  B: imm outside [-4096, 4094] or imm[0]=1
  J: imm outside [-2^20, 2^20-2] or imm[0]=1
  U: imm[11:0] != 0
- Illegal requests are queued as word 0x00000013 (NOP) with out_illegal=1. err_count increments on accept and saturates at all-ones.
- When out_valid=0, out_instr/out_addr/out_illegal hold their last values. They are don't-care for the checker.

Test Plan:
- R add: fmt=0, op=0x33, f3=0, f7b5=0, rd=3, rs1=1, rs2=2, out_ready=1 -> out_instr=0x002081B3, out_addr=0, out_illegal=0. Same request with f7b5=1 (sub) -> 0x402081B3, out_addr=1.
- B/J: beq fmt=3, op=0x63, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3. jal fmt=5, op=0x6F, rd=1, imm=8 -> 0x008000EF.
- Illegal: addi fmt=1, op=0x13, rd=5, rs1=0, imm=2048 -> out_instr=0x00000013, out_illegal=1, err_count=1. Odd B offset imm=3 -> illegal, err_count=2. Saturation check: with ERRCNT_W=2, 5 illegal requests -> err_count=3.
- Backpressure: out_ready=0, offer 3 back-to-back requests -> in_ready drops after 2 accepts and the third is held. Raise out_ready -> 3 words emerge in order at addresses 0,1,2. Simultaneous push+pop at count=1 keeps count=1.
- Wrap and reset: ADDR_W=2, 5 requests -> addresses 0,1,2,3,0. Assert reset_n=0 with 2 words queued -> out_valid=0 immediately, err_count=0, next accepted word gets out_addr=0.

Source files
------------

// File: rtl/rv32i_instr_encoder.sv
// Packs decoded RV32I fields into 32-bit instruction words, tagged with sequential word addresses.
// Latency: a word accepted on edge N is at the output head after edge N (empty FIFO).
// Backpressure: 2-entry output FIFO; in_ready = (count < 2), independent of out_ready.
module rv32i_instr_encoder #(
    parameter int ADDR_W   = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_fmt,
    input  logic [6:0]          in_op,
    input  logic [2:0]          in_funct3,
    input  logic                in_funct7b5,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [31:0]         in_imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_illegal,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [2:0]  FMT_R    = 3'd0;
    localparam logic [2:0]  FMT_I    = 3'd1;
    localparam logic [2:0]  FMT_S    = 3'd2;
    localparam logic [2:0]  FMT_B    = 3'd3;
    localparam logic [2:0]  FMT_U    = 3'd4;
    localparam logic [2:0]  FMT_J    = 3'd5;

    // Head and tail slots; the head is registered so it holds its value after the last pop.
    logic [31:0]         head_instr_q, head_instr_d;
    logic [ADDR_W-1:0]   head_addr_q,  head_addr_d;
    logic                head_ill_q,   head_ill_d;
    logic [31:0]         tail_instr_q, tail_instr_d;
    logic [ADDR_W-1:0]   tail_addr_q,  tail_addr_d;
    logic                tail_ill_q,   tail_ill_d;
    logic [1:0]          count_q,      count_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [ERRCNT_W-1:0] err_q,        err_d;

    logic [31:0] raw_word;
    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        is_shift;
    logic        imm_fits12;
    logic        imm_fits13;
    logic        imm_fits21;
    logic        push;
    logic        pop;

    // A value fits an N-bit signed field when all bits above the field's sign bit match it.
    assign imm_fits12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign imm_fits13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    assign imm_fits21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);
    assign is_shift   = (in_fmt == FMT_I) && (in_op == 7'b0010011) &&
                        ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

    assign in_ready    = (count_q < 2'd2);
    assign out_valid   = (count_q != 2'd0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign out_instr   = head_instr_q;
    assign out_addr    = head_addr_q;
    assign out_illegal = head_ill_q;
    assign err_count   = err_q;

    // Field packing and legality check per format; illegal requests collapse to a NOP.
    always_comb begin
        raw_word    = '0;
        enc_illegal = 1'b0;
        case (in_fmt)
            FMT_R: raw_word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            FMT_I: begin
                if (is_shift) begin
                    raw_word    = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
                    enc_illegal = (in_imm[31:5] != '0);
                end else begin
                    raw_word    = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
                    enc_illegal = !imm_fits12;
                end
            end
            FMT_S: begin
                raw_word    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
                enc_illegal = !imm_fits12;
            end
            FMT_B: begin
                raw_word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_op};
                enc_illegal = !imm_fits13 || in_imm[0];
            end
            FMT_U: begin
                raw_word    = {in_imm[31:12], in_rd, in_op};
                enc_illegal = (in_imm[11:0] != '0);
            end
            FMT_J: begin
                raw_word    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
                enc_illegal = !imm_fits21 || in_imm[0];
            end
            default: enc_illegal = 1'b1;
        endcase
        enc_word = enc_illegal ? NOP_WORD : raw_word;
    end

    // FIFO movement, address stamping and saturating error count.
    always_comb begin
        head_instr_d = head_instr_q;
        head_addr_d  = head_addr_q;
        head_ill_d   = head_ill_q;
        tail_instr_d = tail_instr_q;
        tail_addr_d  = tail_addr_q;
        tail_ill_d   = tail_ill_q;
        count_d      = count_q;
        addr_d       = addr_q;
        err_d        = err_q;

        if (pop && (count_q == 2'd2)) begin
            head_instr_d = tail_instr_q;
            head_addr_d  = tail_addr_q;
            head_ill_d   = tail_ill_q;
        end

        if (push) begin
            if ((count_q == 2'd0) || pop) begin
                head_instr_d = enc_word;
                head_addr_d  = addr_q;
                head_ill_d   = enc_illegal;
            end else begin
                tail_instr_d = enc_word;
                tail_addr_d  = addr_q;
                tail_ill_d   = enc_illegal;
            end
            addr_d = addr_q + 1'b1;
            if (enc_illegal && (err_q != '1)) begin
                err_d = err_q + 1'b1;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards any queued words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_instr_q <= '0;
            head_addr_q  <= '0;
            head_ill_q   <= 1'b0;
            tail_instr_q <= '0;
            tail_addr_q  <= '0;
            tail_ill_q   <= 1'b0;
            count_q      <= '0;
            addr_q       <= '0;
            err_q        <= '0;
        end else begin
            head_instr_q <= head_instr_d;
            head_addr_q  <= head_addr_d;
            head_ill_q   <= head_ill_d;
            tail_instr_q <= tail_instr_d;
            tail_addr_q  <= tail_addr_d;
            tail_ill_q   <= tail_ill_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Testbench for rv32i_instr_encoder: directed scenarios plus a randomized run against a reference model.
// Narrow address and error counters so wrap and saturation are reachable quickly.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_rv32i_instr_encoder;

    localparam int AW = 2;
    localparam int EW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_fmt = '0;
    logic [6:0]    in_op = '0;
    logic [2:0]    in_funct3 = '0;
    logic          in_funct7b5 = 1'b0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          out_illegal;
    logic [EW-1:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
        logic          ill;
    } exp_t;

    exp_t q[$];
    int   m_addr;
    int   m_err;

    rv32i_instr_encoder #(.ADDR_W(AW), .ERRCNT_W(EW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_illegal(out_illegal), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Bits hi..lo of v, right-aligned.
    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        logic [31:0] mask;
        mask = (32'd1 << (hi - lo + 1)) - 32'd1;
        return (v >> lo) & mask;
    endfunction

    // Reference encoder: range rules on the signed integer value, fields placed by shifting.
    function automatic void ref_encode(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                       input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [31:0] imm,
                                       output logic [31:0] w, output logic ill);
        int          s;
        logic [31:0] common;
        s      = $signed(imm);
        common = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        w      = 32'h0;
        ill    = 1'b0;
        case (fmt)
            3'd0: w = (32'(f7) << 30) | (32'(rs2) << 20) | common | (32'(rd) << 7);
            3'd1: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    ill = (s < 0) || (s > 31);
                    w   = (32'(f7) << 30) | (fld(imm, 4, 0) << 20) | common | (32'(rd) << 7);
                end else begin
                    ill = (s < -2048) || (s > 2047);
                    w   = (fld(imm, 11, 0) << 20) | common | (32'(rd) << 7);
                end
            end
            3'd2: begin
                ill = (s < -2048) || (s > 2047);
                w   = (fld(imm, 11, 5) << 25) | (32'(rs2) << 20) | common | (fld(imm, 4, 0) << 7);
            end
            3'd3: begin
                ill = (s < -4096) || (s > 4094) || (s % 2 != 0);
                w   = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (32'(rs2) << 20) | common |
                      (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7);
            end
            3'd4: begin
                ill = (imm % 32'd4096) != 32'd0;
                w   = (fld(imm, 31, 12) << 12) | (32'(rd) << 7) | 32'(op);
            end
            3'd5: begin
                ill = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (s % 2 != 0);
                w   = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20) |
                      (fld(imm, 19, 12) << 12) | (32'(rd) << 7) | 32'(op);
            end
            default: ill = 1'b1;
        endcase
        if (ill) w = 32'h0000_0013;
    endfunction

    // Records the word the DUT is expected to accept at the coming rising edge.
    function automatic void predict();
        exp_t        e;
        logic [31:0] w;
        logic        ill;
        ref_encode(in_fmt, in_op, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, w, ill);
        e.instr = w;
        e.addr  = AW'(m_addr);
        e.ill   = ill;
        q.push_back(e);
        m_addr = (m_addr + 1) % (1 << AW);
        if (ill && m_err < (1 << EW) - 1) m_err++;
    endfunction

    task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        in_fmt = fmt; in_op = op; in_funct3 = f3; in_funct7b5 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_req(3'd0, 7'h0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        q.delete(); m_addr = 0; m_err = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
        n_tests++; if (out_addr !== '0) begin n_fail++; $display("FAIL reset_out_addr got %0d want 0", out_addr); end
        n_tests++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_illegal got %b want 0", out_illegal); end
        n_tests++; if (err_count !== '0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_r_type();
        do_reset();
        out_ready = 1'b1;
        set_req(3'd0, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0);
        in_valid = 1'b1;
        @(negedge clk);
        n_tests++; if (out_instr !== 32'h002081B3 || out_addr !== 2'd0 || out_illegal !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL r_add got v=%b %h @%0d ill=%b want 002081b3 @0 ill=0", out_valid, out_instr, out_addr, out_illegal);
        end
        // Push and pop together with one word queued.
        set_req(3'd0, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0);
        @(negedge clk);
        n_tests++; if (out_instr !== 32'h402081B3 || out_addr !== 2'd1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL r_sub got v=%b %h @%0d want 402081b3 @1", out_valid, out_instr, out_addr);
        end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pushpop_count1 in_ready got %b want 1", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL r_drain out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_branch_jump();
        do_reset();
        out_ready = 1'b1;
        set_req(3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        in_valid = 1'b1;
        @(negedge clk);
        n_tests++; if (out_instr !== 32'hFE208EE3 || out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL beq got %h ill=%b want fe208ee3 ill=0", out_instr, out_illegal);
        end
        set_req(3'd5, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        @(negedge clk);
        n_tests++; if (out_instr !== 32'h008000EF || out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL jal got %h ill=%b want 008000ef ill=0", out_instr, out_illegal);
        end
        set_req(3'd1, 7'h13, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd31);
        @(negedge clk);
        n_tests++; if (out_instr !== 32'h41F35293 || out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL srai got %h ill=%b want 41f35293 ill=0", out_instr, out_illegal);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [31:0] imms [5];
        logic [2:0]  fmts [5];
        logic [2:0]  f3s  [5];
        imms = '{32'd2048, 32'd3, 32'd0, 32'h123, 32'd32};
        fmts = '{3'd1, 3'd3, 3'd6, 3'd4, 3'd1};
        f3s  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_req(fmts[k], (fmts[k] == 3'd3) ? 7'h63 : 7'h13, f3s[k], 1'b0, 5'd5, 5'd0, 5'd2, imms[k]);
            in_valid = 1'b1;
            @(negedge clk);
            n_tests++; if (out_instr !== 32'h13 || out_illegal !== 1'b1 || err_count !== EW'((k < 3) ? k + 1 : 3)) begin
                n_fail++; $display("FAIL illegal_%0d got %h ill=%b err=%0d want 00000013 ill=1 err=%0d",
                                   k, out_instr, out_illegal, err_count, (k < 3) ? k + 1 : 3);
            end
        end
        set_req(3'd1, 7'h13, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_F800);
        @(negedge clk);
        n_tests++; if (out_instr !== 32'h80000293 || out_illegal !== 1'b0 || err_count !== 2'd3) begin
            n_fail++; $display("FAIL addi_min got %h ill=%b err=%0d want 80000293 ill=0 err=3", out_instr, out_illegal, err_count);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            set_req(3'd1, 7'h13, 3'd0, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k));
            in_valid = 1'b1;
            n_tests++; if (in_ready !== (k < 3)) begin
                n_fail++; $display("FAIL bp_in_ready_%0d got %b want %b", k, in_ready, k < 3);
            end
            @(negedge clk);
        end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_held got in_ready=%b want 0", in_ready); end
        out_ready = 1'b1;
        n_tests++; if (out_instr !== 32'h00100093 || out_addr !== 2'd0) begin
            n_fail++; $display("FAIL bp_word0 got %h @%0d want 00100093 @0", out_instr, out_addr);
        end
        @(negedge clk);
        n_tests++; if (out_instr !== 32'h00200113 || out_addr !== 2'd1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_word1 got %h @%0d rdy=%b want 00200113 @1 rdy=1", out_instr, out_addr, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_instr !== 32'h00300193 || out_addr !== 2'd2 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_word2 got v=%b %h @%0d rdy=%b want 00300193 @2 rdy=1", out_valid, out_instr, out_addr, in_ready);
        end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_req(3'd1, 7'h13, 3'd0, 1'b0, 5'(k), 5'd0, 5'd0, 32'd0);
            in_valid = 1'b1;
            @(negedge clk);
            n_tests++; if (out_addr !== AW'(k % 4) || out_instr !== ((32'(k) << 7) | 32'h13)) begin
                n_fail++; $display("FAIL wrap_%0d got %h @%0d want @%0d", k, out_instr, out_addr, k % 4);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        set_req(3'd7, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        set_req(3'd1, 7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd4);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || err_count !== 2'd1) begin
            n_fail++; $display("FAIL pre_reset got v=%b rdy=%b err=%0d want v=1 rdy=0 err=1", out_valid, in_ready, err_count);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || err_count !== '0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset got v=%b err=%0d rdy=%b want v=0 err=0 rdy=1", out_valid, err_count, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        set_req(3'd1, 7'h13, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd7);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_addr !== 2'd0 || out_instr !== 32'h00700193) begin
            n_fail++; $display("FAIL post_reset got v=%b %h @%0d want 00700193 @0", out_valid, out_instr, out_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [6:0]  ops [8];
        logic [31:0] imm;
        logic        full;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67};
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            n_tests++; if (out_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, out_valid, q.size() != 0);
            end
            n_tests++; if (in_ready !== (q.size() < 2)) begin
                n_fail++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, in_ready, q.size() < 2);
            end
            n_tests++; if (err_count !== EW'(m_err)) begin
                n_fail++; $display("FAIL rnd_err cyc %0d got %0d want %0d", c, err_count, m_err);
            end
            if (q.size() != 0) begin
                n_tests++; if (out_instr !== q[0].instr || out_addr !== q[0].addr || out_illegal !== q[0].ill) begin
                    n_fail++; $display("FAIL rnd_head cyc %0d got %h @%0d ill=%b want %h @%0d ill=%b",
                                       c, out_instr, out_addr, out_illegal, q[0].instr, q[0].addr, q[0].ill);
                end
            end
            case ($urandom_range(0, 4))
                0:       imm = $urandom;
                1:       imm = $urandom_range(0, 40);
                2:       imm = $urandom & 32'hFFFF_F000;
                3:       imm = 32'($urandom_range(0, 12000)) - 32'd6000;
                default: imm = 32'($urandom_range(0, 2200000)) - 32'd1100000;
            endcase
            set_req(3'($urandom_range(0, 7)), ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom),
                    5'($urandom), 5'($urandom), 5'($urandom), imm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            full = (q.size() >= 2);
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && !full) predict();
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_branch_jump();
        test_illegal();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
